// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath width and memory sequencer state type
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - saturating cycle counter with synchronous clear and enable
module wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request memory access sequencer with min-wait ack qualification
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);

  if ((2 ** CNT_W) <= MIN_WAIT || (2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
    $error("mem_access_ctrl: CNT_W too narrow for MIN_WAIT/TIMEOUT");
  end

  mem_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             ack_ok;
  logic             timeout_hit;

  // Counter sits at zero while idle so it starts every access from zero.
  wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .enable (state == ACCESS),
    .count  (wait_cnt)
  );

  assign ack_ok = mem_ack && (wait_cnt >= MIN_WAIT_C);

`ifdef MEM_TIMEOUT_EN
  // Fires in the ACCESS cycle whose closing edge brings the count to TIMEOUT.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  assign timeout_hit = (wait_cnt >= TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            mem_ce    <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          // A qualified ack beats a timeout reached in the same cycle.
          if (ack_ok || timeout_hit) begin
            state     <= DONE;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= !ack_ok;
            if (ack_ok && !mem_we) begin
              rsp_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_ce    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl (MIN_WAIT=1, TIMEOUT=15)
module tb_mem_access_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic         mem_ce;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_count = 0;
  int ce_cycles = 0;
  int n0 = 0;

  logic         exp_we = 1'b0;
  logic [W-1:0] exp_addr = '0;
  logic [W-1:0] exp_wdata = '0;
  rsp_t         exp_q[$];

  mem_access_ctrl #(
    .WIDTH    (W),
    .MIN_WAIT (1),
    .TIMEOUT  (15),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_ce) begin
      ce_cycles++;
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    end
    if (rsp_valid) begin
      rsp_t e;
      rsp_count++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Controller must be idle on entry; acceptance happens on the next rising edge.
  task automatic issue(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       input bit hold);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    ce_cycles = 0;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev, input int budget);
    int k;
    k = 0;
    while (rsp_count == prev && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rsp_count == prev) chk("rsp_wait_budget", 32'd0, 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish expected finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Read with ack tied high: one ignored ACCESS cycle, then completion.
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    exp_we = 1'b0; exp_addr = 16'h3000;
    exp_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h3000, 16'h0000, 1'b0);
    wait_rsp(n0, 20);
    chk("t1_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
    chk("t1_ce_cycles", 32'(ce_cycles), 32'd2);
    @(negedge clk);
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    chk("t1_idle_ack_ignored", 32'(rsp_count), 32'(n0 + 1));
    chk("t1_rdata_hold", 32'(rsp_rdata), 32'hBEEF);
    mem_ack = 1'b0;

    // Write acked in the third ACCESS cycle; read data must not change.
    mem_rdata = 16'h1234;
    exp_we = 1'b1; exp_addr = 16'h0010; exp_wdata = 16'hA5A5;
    exp_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
    n0 = rsp_count;
    issue(1'b1, 16'h0010, 16'hA5A5, 1'b0);
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    wait_rsp(n0, 20);
    chk("t2_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    chk("t2_ce_cycles", 32'(ce_cycles), 32'd3);
    repeat (2) @(negedge clk);
    chk("t2_rdata_kept", 32'(rsp_rdata), 32'hBEEF);

    // Ack in the first ACCESS cycle (count 0 < MIN_WAIT) is ignored.
    mem_rdata = 16'hC0DE;
    exp_we = 1'b0; exp_addr = 16'h0200;
    exp_q.push_back('{rdata: 16'hC0DE, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h0200, 16'h0000, 1'b0);
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    wait_rsp(n0, 20);
    chk("t3_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    chk("t3_ce_cycles", 32'(ce_cycles), 32'd3);
    repeat (2) @(negedge clk);

    // req_valid held through ACCESS/DONE with changing fields.
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    exp_we = 1'b0; exp_addr = 16'h0400;
    exp_q.push_back('{rdata: 16'h4444, err: 1'b0});
    exp_q.push_back('{rdata: 16'h4444, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h0400, 16'h0000, 1'b1);
    req_we = 1'b1; req_addr = 16'h0500; req_wdata = 16'h7777;
    wait_rsp(n0, 20);
    chk("t4_first_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
    chk("t4_ready_in_done", 32'(req_ready), 32'd0);
    exp_we = 1'b1; exp_addr = 16'h0500; exp_wdata = 16'h7777;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    ce_cycles = 0;
    chk("t4_second_accept", 32'(busy), 32'd1);
    wait_rsp(n0 + 1, 20);
    chk("t4_second_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
    chk("t4_second_ce", 32'(ce_cycles), 32'd2);
    repeat (4) @(negedge clk);
    chk("t4_rsp_count", 32'(rsp_count), 32'(n0 + 2));
    mem_ack = 1'b0;

    // Reset asserted mid-ACCESS aborts with no response.
    exp_we = 1'b0; exp_addr = 16'h0800;
    n0 = rsp_count;
    issue(1'b0, 16'h0800, 16'h0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ce_async", 32'(mem_ce), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_count), 32'(n0));

    // Normal read after reset recovery.
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    exp_we = 1'b0; exp_addr = 16'h0600;
    exp_q.push_back('{rdata: 16'h5A5A, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h0600, 16'h0000, 1'b0);
    wait_rsp(n0, 20);
    chk("t6_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 15 ACCESS cycles with rdata untouched.
    mem_rdata = 16'hDEAD;
    exp_we = 1'b0; exp_addr = 16'h0700;
    exp_q.push_back('{rdata: 16'h5A5A, err: 1'b1});
    n0 = rsp_count;
    issue(1'b0, 16'h0700, 16'h0000, 1'b0);
    wait_rsp(n0, 40);
    chk("t7_timeout_latency", 32'(rsp_cyc - acc_cyc), 32'd15);
    chk("t7_timeout_ce", 32'(ce_cycles), 32'd15);
    repeat (2) @(negedge clk);
    chk("t7_rdata_kept", 32'(rsp_rdata), 32'h5A5A);

    // Ack in ACCESS cycle 15 wins over the timeout.
    mem_rdata = 16'h0F0F;
    exp_addr = 16'h0710;
    exp_q.push_back('{rdata: 16'h0F0F, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h0710, 16'h0000, 1'b0);
    repeat (14) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    wait_rsp(n0, 40);
    chk("t8_ack_latency", 32'(rsp_cyc - acc_cyc), 32'd15);
    chk("t8_ack_ce", 32'(ce_cycles), 32'd15);
`else
    // Without the timeout the access waits past 15 cycles for its ack.
    mem_rdata = 16'h0F0F;
    exp_we = 1'b0; exp_addr = 16'h0700;
    exp_q.push_back('{rdata: 16'h0F0F, err: 1'b0});
    n0 = rsp_count;
    issue(1'b0, 16'h0700, 16'h0000, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t7_still_busy", 32'(busy), 32'd1);
    chk("t7_no_rsp_yet", 32'(rsp_count), 32'(n0));
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    wait_rsp(n0, 20);
    chk("t7_long_latency", 32'(rsp_cyc - acc_cyc), 32'd21);
    chk("t7_long_ce", 32'(ce_cycles), 32'd21);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
